// File: rtl/decimator_avg_if.sv
// Sample-stream interface of the boxcar decimator: 48 kHz input side,
// low-rate averaged output side plus status.
interface decimator_avg_if #(
   parameter int DW = 18,
   parameter int NW = 4
);
   logic                 i_endatain;
   logic [NW-1:0]        i_nfreq;
   logic signed [DW-1:0] i_datain;
   logic signed [DW-1:0] o_dataout;
   logic                 o_endataout;
   logic                 o_busy;
   logic                 o_overrun;

   modport master (
      output i_endatain, i_nfreq, i_datain,
      input  o_dataout, o_endataout, o_busy, o_overrun
   );

   modport slave (
      input  i_endatain, i_nfreq, i_datain,
      output o_dataout, o_endataout, o_busy, o_overrun
   );
endinterface

// File: rtl/decimator_avg.sv
// Boxcar decimator: sums Nfreq samples and divides by Nfreq with a serial restoring divider.
// Optional DECIMATOR_ROUND_EN selects round-half-away-from-zero instead of truncation.
module decimator_avg #(
   parameter int DW = 18,
   parameter int NW = 4,
   parameter int AW = DW + NW
) (
   input logic            i_clock,
   input logic            i_reset_n,
   decimator_avg_if.slave bus
);
   localparam int IW = $clog2(AW);

   typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

   state_t               r_state, w_state_nxt;
   logic [NW-1:0]        r_nf_l, r_cnt, r_div, r_rem;
   logic signed [AW-1:0] r_accum;
   logic [AW-1:0]        r_dvd;
   logic [IW-1:0]        r_iter;
   logic                 r_sign;
   logic signed [DW-1:0] r_dataout;
   logic                 r_endataout, r_overrun;

   logic [NW-1:0]        w_nf_in, w_nf_cur;
   logic                 w_last, w_accept, w_ge;
   logic signed [AW-1:0] w_sext, w_sum;
   logic [AW-1:0]        w_abs, w_dvd_ld;
   logic [NW:0]          w_rem_sh, w_rem_nx;
   logic [DW-1:0]        w_res;

   // The factor in force is the live input on a block's first sample, the latched one after.
   assign w_nf_in  = (bus.i_nfreq == '0) ? NW'(1) : bus.i_nfreq;
   assign w_nf_cur = (r_cnt == '0) ? w_nf_in : r_nf_l;
   assign w_last   = bus.i_endatain && (r_cnt == w_nf_cur - NW'(1));
   assign w_accept = w_last && (r_state != DIV);

   assign w_sext = {{(AW-DW){bus.i_datain[DW-1]}}, bus.i_datain};
   assign w_sum  = r_accum + w_sext;
   assign w_abs  = w_sum[AW-1] ? (~w_sum + AW'(1)) : w_sum;

`ifdef DECIMATOR_ROUND_EN
   assign w_dvd_ld = w_abs + AW'(w_nf_cur >> 1);
`else
   assign w_dvd_ld = w_abs;
`endif

   // Remainder stays below the divisor, so NW bits hold it between steps.
   assign w_rem_sh = {r_rem, r_dvd[AW-1]};
   assign w_ge     = (w_rem_sh >= {1'b0, r_div});
   assign w_rem_nx = w_ge ? (w_rem_sh - {1'b0, r_div}) : w_rem_sh;
   assign w_res    = r_sign ? (~r_dvd[DW-1:0] + DW'(1)) : r_dvd[DW-1:0];

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) r_state <= IDLE;
      else            r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_state_nxt = DIV;
         DIV:     if (r_iter == IW'(AW-1)) w_state_nxt = DONE;
         DONE:    w_state_nxt = w_accept ? DIV : IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_nf_l      <= NW'(1);
         r_cnt       <= '0;
         r_accum     <= '0;
         r_div       <= NW'(1);
         r_rem       <= '0;
         r_dvd       <= '0;
         r_iter      <= '0;
         r_sign      <= 1'b0;
         r_dataout   <= '0;
         r_endataout <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         if (bus.i_endatain) begin
            if (r_cnt == '0) r_nf_l <= w_nf_in;
            if (w_last) begin
               r_accum <= '0;
               r_cnt   <= '0;
            end else begin
               r_accum <= w_sum;
               r_cnt   <= r_cnt + NW'(1);
            end
         end

         if (w_accept) begin
            r_dvd  <= w_dvd_ld;
            r_sign <= w_sum[AW-1];
            r_div  <= w_nf_cur;
            r_rem  <= '0;
            r_iter <= '0;
         end else if (r_state == DIV) begin
            r_rem  <= w_rem_nx[NW-1:0];
            r_dvd  <= {r_dvd[AW-2:0], w_ge};
            r_iter <= r_iter + IW'(1);
         end

         if (w_last && r_state == DIV) r_overrun <= 1'b1;

         r_endataout <= (r_state == DONE);
         if (r_state == DONE) r_dataout <= w_res;
      end
   end

   assign bus.o_dataout   = r_dataout;
   assign bus.o_endataout = r_endataout;
   assign bus.o_busy      = (r_state == DIV);
   assign bus.o_overrun   = r_overrun;
endmodule

// File: tb/tb_decimator_avg.sv
// Bench for decimator_avg: directed vector table, corner sequences and random blocks
// scored against a block-average model.
module tb_decimator_avg;
   localparam int DW  = 18;
   localparam int NW  = 4;
   localparam int AW  = 22;
   localparam int LAT = 24;
`ifdef DECIMATOR_ROUND_EN
   localparam bit RND = 1'b1;
`else
   localparam bit RND = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc    = 0;
   int   n_chk  = 0;
   int   n_fail = 0;

   decimator_avg_if #(.DW(DW), .NW(NW)) bus();

   decimator_avg #(.DW(DW), .NW(NW), .AW(AW)) dut (
      .i_clock   (clk),
      .i_reset_n (rst_n),
      .bus       (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {int c; int v;} exp_t;
   typedef struct {int nf; int n; int gap; int s[15]; int et; int er;} vec_t;

   exp_t expq[$];
   int   blk[$];
   int   m_nf       = 1;
   int   m_last_acc = -1000;
   bit   m_ovr      = 1'b0;
   vec_t tbl[10];

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic int ref_avg(input int sum, input int nf);
      int mag;
      if (!RND) return sum / nf;
      mag = (sum < 0) ? -sum : sum;
      mag = (mag + nf / 2) / nf;
      return (sum < 0) ? -mag : mag;
   endfunction

   // A block is taken only if the divider finished its AW steps for the previous one.
   task automatic model_sample(input int c, input int nf, input int v);
      int sum;
      if (blk.size() == 0) m_nf = (nf == 0) ? 1 : nf;
      blk.push_back(v);
      if (blk.size() == m_nf) begin
         sum = 0;
         foreach (blk[i]) sum += blk[i];
         if (c - m_last_acc > AW) begin
            expq.push_back('{c + LAT, ref_avg(sum, m_nf)});
            m_last_acc = c;
         end else begin
            m_ovr = 1'b1;
         end
         blk.delete();
      end
   endtask

   task automatic model_reset();
      blk.delete();
      expq.delete();
      m_last_acc = -1000;
      m_ovr      = 1'b0;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus.o_endataout) begin
         if (expq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_strobe: got dataout %0d at cycle %0d, required none", bus.o_dataout, cyc);
         end else begin
            e = expq.pop_front();
            chk("strobe_cycle", cyc, e.c);
            chk("strobe_value", bus.o_dataout, e.v);
         end
      end
   end

   // gap = clocks from the previous pulse (>= 2); c returns the cycle the pulse is high.
   task automatic send(input int nf, input int v, input int gap, output int c);
      repeat (gap - 2) @(negedge clk);
      @(negedge clk);
      bus.i_nfreq    = NW'(nf);
      bus.i_datain   = DW'(v);
      bus.i_endatain = 1'b1;
      c = cyc;
      model_sample(cyc, nf, v);
      @(negedge clk);
      bus.i_endatain = 1'b0;
   endtask

   task automatic wait_strobe(input int c0, input int expv, input string nm);
      int k = 0;
      while (!bus.o_endataout && k < 40) begin
         @(negedge clk);
         k++;
      end
      if (!bus.o_endataout) chk({nm, "_timeout"}, bus.o_endataout, 1);
      else begin
         chk({nm, "_lat"}, cyc - c0, LAT);
         chk({nm, "_val"}, bus.o_dataout, expv);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int c, seen, nf, v, gap;
      bus.i_endatain = 1'b0;
      bus.i_nfreq    = '0;
      bus.i_datain   = '0;

      tbl[0] = '{4, 4, 1000, '{0:100, 1:200, 2:300, 3:401, default:0}, 250, 250};
      tbl[1] = '{4, 4, 40, '{0:100, 1:200, 2:300, 3:402, default:0}, 250, 251};
      tbl[2] = '{3, 3, 40, '{0:-5, 1:-5, 2:-4, default:0}, -4, -5};
      tbl[3] = '{10, 10, 30, '{default:131071}, 131071, 131071};
      tbl[4] = '{10, 10, 30, '{default:-131072}, -131072, -131072};
      tbl[5] = '{0, 1, 40, '{0:12345, default:0}, 12345, 12345};
      tbl[6] = '{0, 1, 40, '{0:-7, default:0}, -7, -7};
      tbl[7] = '{15, 15, 30, '{default:131071}, 131071, 131071};
      tbl[8] = '{2, 2, 40, '{0:6, 1:8, default:0}, 7, 7};
      tbl[9] = '{7, 7, 30, '{0:1, 1:2, 2:3, 3:4, 4:5, 5:6, 6:-1, default:0}, 2, 3};

      repeat (3) @(negedge clk);
      chk("rst_dataout", bus.o_dataout, 0);
      chk("rst_endataout", bus.o_endataout, 0);
      chk("rst_busy", bus.o_busy, 0);
      chk("rst_overrun", bus.o_overrun, 0);
      rst_n = 1'b1;

      seen = 0;
      repeat (100) begin
         @(negedge clk);
         if (bus.o_endataout || bus.o_busy) seen++;
      end
      chk("idle_activity", seen, 0);
      chk("idle_dataout", bus.o_dataout, 0);

      for (int r = 0; r < 10; r++) begin
         for (int i = 0; i < tbl[r].n; i++)
            send(tbl[r].nf, tbl[r].s[i], (i == 0) ? 40 : tbl[r].gap, c);
         wait_strobe(c, RND ? tbl[r].er : tbl[r].et, $sformatf("row%0d", r));
      end
      chk("legal_no_overrun", bus.o_overrun, 0);

      // Factor change mid-block only applies from the next block on.
      send(4, 10, 40, c);
      send(4, 20, 30, c);
      send(2, 30, 30, c);
      send(2, 40, 30, c);
      wait_strobe(c, 25, "nfchg_a");
      send(2, 50, 30, c);
      send(2, 70, 30, c);
      wait_strobe(c, 60, "nfchg_b");

      send(1, 1, 40, c);
      send(1, 2, 10, c);
      send(1, 3, 10, c);
      send(1, 4, 10, c);
      repeat (40) @(negedge clk);
      chk("overrun_sticky", bus.o_overrun, 1);
      chk("overrun_last_val", bus.o_dataout, 4);

      send(2, 100, 40, c);
      send(2, 200, 2, c);
      repeat (9) @(negedge clk);
      chk("busy_in_div", bus.o_busy, 1);
      rst_n = 1'b0;
      #1;
      chk("midrst_dataout", bus.o_dataout, 0);
      chk("midrst_busy", bus.o_busy, 0);
      chk("midrst_overrun", bus.o_overrun, 0);
      chk("midrst_endataout", bus.o_endataout, 0);
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.o_endataout) seen++;
      end
      chk("midrst_no_strobe", seen, 0);
      send(2, 6, 5, c);
      send(2, 8, 5, c);
      wait_strobe(c, 7, "post_rst");

      for (int i = 0; i < 60; i++) begin
         nf  = int'($urandom_range(0, 15));
         v   = int'($urandom_range(0, 262143)) - 131072;
         gap = ($urandom_range(0, 7) == 0) ? 5 : int'($urandom_range(26, 40));
         send(nf, v, gap, c);
      end
      repeat (40) @(negedge clk);
      chk("rand_drain", expq.size(), 0);
      chk("rand_overrun", bus.o_overrun, int'(m_ovr));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
